// File: rtl/dll_code_ctrl.sv
// rtl/dll_code_ctrl.sv - DLL delay-code controller: coarse search, fine tracking, lock and drift detection
// Phase decisions are taken once per rising edge of the divided-reference strobe DIV_M.
module dll_code_ctrl #(
    parameter int CODE_W      = 6,
    parameter int INIT_CODE   = 32,
    parameter int COARSE_STEP = 4,
    parameter int LOCK_CNT    = 4
) (
    input  logic              clk_ext,
    input  logic              rst,
    input  logic              DIV_M,
    input  logic [1:0]        Sel,
    output logic [CODE_W-1:0] Code,
    output logic              Lock,
    output logic [1:0]        State,
    output logic              Sat
);

    typedef enum logic [1:0] {
        ST_COARSE = 2'b00,
        ST_FINE   = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DN   = 2'b10
    } dir_t;

    localparam int              HW       = $clog2(LOCK_CNT + 1);
    localparam logic [CODE_W:0] CODE_MAX = {1'b0, {CODE_W{1'b1}}};
    localparam logic [CODE_W:0] STEP_C   = (CODE_W + 1)'(COARSE_STEP);
    localparam logic [CODE_W:0] STEP_F   = (CODE_W + 1)'(1);

    state_t            state_q, state_d;
    dir_t              last_q, last_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              drift_q, drift_d;
    logic              lock_q, sat_q, sat_d;
    logic              div_m_q;

    logic              upd, is_up, is_dn, is_hold, same_dir, big;
    logic [CODE_W:0]   amt, up_sum, dn_diff;
    logic [CODE_W-1:0] up_code, dn_code;
    logic              sat_hit;

    assign upd      = DIV_M & ~div_m_q;
    assign is_up    = (Sel == 2'b01);
    assign is_dn    = (Sel == 2'b10);
    assign is_hold  = (Sel == 2'b00);
    assign same_dir = (is_up && last_q == DIR_UP) || (is_dn && last_q == DIR_DN);
    assign big      = (state_q == ST_COARSE) && ((last_q == DIR_NONE) || same_dir);

    // One extra bit catches overflow above the max code and borrow below zero.
    assign amt     = big ? STEP_C : STEP_F;
    assign up_sum  = {1'b0, code_q} + amt;
    assign dn_diff = {1'b0, code_q} - amt;
    assign up_code = (up_sum > CODE_MAX) ? CODE_MAX[CODE_W-1:0] : up_sum[CODE_W-1:0];
    assign dn_code = dn_diff[CODE_W] ? '0 : dn_diff[CODE_W-1:0];
    assign sat_hit = (is_up && code_q == CODE_MAX[CODE_W-1:0]) || (is_dn && code_q == '0);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        last_d  = last_q;
        hold_d  = hold_q;
        drift_d = drift_q;
        sat_d   = 1'b0;
        if (upd) begin
            if (is_up || is_dn) begin
                code_d = is_up ? up_code : dn_code;
                sat_d  = sat_hit;
                last_d = is_up ? DIR_UP : DIR_DN;
            end
            case (state_q)
                ST_COARSE: begin
                    if ((is_up || is_dn) && !big) begin
                        state_d = ST_FINE;
                        hold_d  = '0;
                    end
                end
                ST_FINE: begin
                    if (is_hold) begin
                        if (hold_q == HW'(LOCK_CNT - 1)) begin
                            state_d = ST_LOCKED;
                            hold_d  = '0;
                            drift_d = 1'b0;
                        end else begin
                            hold_d = hold_q + HW'(1);
                        end
                    end else begin
                        hold_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // Two same-direction corrections in a row mean the lock has been lost.
                    if (is_up || is_dn) begin
                        if (drift_q && same_dir) begin
                            state_d = ST_FINE;
                            drift_d = 1'b0;
                            hold_d  = '0;
                        end else begin
                            drift_d = 1'b1;
                        end
                    end else begin
                        drift_d = 1'b0;
                    end
                end
                default: state_d = ST_COARSE;
            endcase
        end
    end

    always_ff @(posedge clk_ext or posedge rst) begin
        if (rst) begin
            state_q <= ST_COARSE;
            code_q  <= CODE_W'(INIT_CODE);
            last_q  <= DIR_NONE;
            hold_q  <= '0;
            drift_q <= 1'b0;
            lock_q  <= 1'b0;
            sat_q   <= 1'b0;
            div_m_q <= 1'b1;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            drift_q <= drift_d;
            lock_q  <= (state_d == ST_LOCKED);
            sat_q   <= sat_d;
            div_m_q <= DIV_M;
        end
    end

    assign Code  = code_q;
    assign Lock  = lock_q;
    assign State = state_q;
    assign Sat   = sat_q;

endmodule

// File: tb/tb_dll_code_ctrl.sv
// tb/tb_dll_code_ctrl.sv - self-checking bench for dll_code_ctrl: vector table, corner sequences, random vs model
module tb_dll_code_ctrl;

    localparam int MAXC = 63;
    localparam int STEP = 4;
    localparam int LCNT = 4;
    localparam int INIT = 32;

    logic       clk_ext = 1'b0;
    logic       rst     = 1'b1;
    logic       DIV_M   = 1'b0;
    logic [1:0] Sel     = 2'b00;
    logic [5:0] Code;
    logic       Lock;
    logic [1:0] State;
    logic       Sat;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: code as integer, direction as +1/-1/0, state 0/1/2.
    int m_code, m_state, m_last, m_hold, m_drift, m_lock, m_sat;

    typedef struct {
        bit         rst_first;
        logic [1:0] sel;
        int         code;
        int         st;
        int         lock;
        int         sat;
    } vec_t;

    vec_t vt[$];

    dll_code_ctrl dut (
        .clk_ext (clk_ext),
        .rst     (rst),
        .DIV_M   (DIV_M),
        .Sel     (Sel),
        .Code    (Code),
        .Lock    (Lock),
        .State   (State),
        .Sat     (Sat)
    );

    always #5 clk_ext = ~clk_ext;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input bit r, input logic [1:0] s, input int c, input int st, input int lk, input int sa);
        vec_t v;
        v.rst_first = r; v.sel = s; v.code = c; v.st = st; v.lock = lk; v.sat = sa;
        vt.push_back(v);
    endfunction

    task automatic model_reset();
        m_code = INIT; m_state = 0; m_last = 0; m_hold = 0; m_drift = 0; m_lock = 0; m_sat = 0;
    endtask

    task automatic model_upd(input int s);
        int dir, delta, nc;
        bit same;
        m_sat = 0;
        if (s == 1 || s == 2) begin
            dir  = (s == 1) ? 1 : -1;
            same = (m_last == dir);
            if (m_state == 0) begin
                if (m_last == 0 || same) delta = dir * STEP;
                else begin delta = dir; m_state = 1; m_hold = 0; end
            end else if (m_state == 1) begin
                delta = dir; m_hold = 0;
            end else begin
                delta = dir;
                if (m_drift >= 1 && same) begin m_state = 1; m_drift = 0; m_hold = 0; end
                else m_drift = 1;
            end
            m_sat = ((dir > 0 && m_code == MAXC) || (dir < 0 && m_code == 0)) ? 1 : 0;
            nc = m_code + delta;
            m_code = (nc > MAXC) ? MAXC : (nc < 0) ? 0 : nc;
            m_last = dir;
        end else if (m_state == 1) begin
            if (s == 0) begin
                m_hold++;
                if (m_hold == LCNT) begin m_state = 2; m_hold = 0; m_drift = 0; end
            end else m_hold = 0;
        end else if (m_state == 2) begin
            m_drift = 0;
        end
        m_lock = (m_state == 2) ? 1 : 0;
    endtask

    task automatic do_reset();
        @(negedge clk_ext);
        rst = 1'b1; DIV_M = 1'b0;
        repeat (2) @(negedge clk_ext);
        rst = 1'b0;
        model_reset();
        chk("rst_code", int'(Code), INIT);
        chk("rst_state", int'(State), 0);
        chk("rst_lock", int'(Lock), 0);
        chk("rst_sat", int'(Sat), 0);
    endtask

    task automatic strobe(input logic [1:0] s, input int width, output int c, output int st, output int lk, output int sa);
        @(negedge clk_ext);
        DIV_M = 1'b1; Sel = s;
        model_upd(int'(s));
        @(negedge clk_ext);
        Sel = 2'($urandom);
        c = int'(Code); st = int'(State); lk = int'(Lock); sa = int'(Sat);
        chk("upd_code", c, m_code);
        chk("upd_state", st, m_state);
        chk("upd_lock", lk, m_lock);
        chk("upd_sat", sa, m_sat);
        for (int i = 1; i < width; i++) begin
            @(negedge clk_ext);
            Sel = 2'($urandom);
            chk("held_code", int'(Code), m_code);
            chk("held_sat", int'(Sat), 0);
        end
        DIV_M = 1'b0;
        @(negedge clk_ext);
        Sel = 2'($urandom);
        chk("post_code", int'(Code), m_code);
        chk("post_state", int'(State), m_state);
        chk("post_sat", int'(Sat), 0);
    endtask

    initial begin
        int c, st, lk, sa, r, w;
        logic [1:0] s;

        // Coarse reversal, lock with INVALID restart, drift, relock, UP/DN/UP stays locked.
        add(1, 2'b01, 36, 0, 0, 0); add(0, 2'b01, 40, 0, 0, 0); add(0, 2'b01, 44, 0, 0, 0);
        add(0, 2'b10, 43, 1, 0, 0);
        add(0, 2'b00, 43, 1, 0, 0); add(0, 2'b00, 43, 1, 0, 0); add(0, 2'b11, 43, 1, 0, 0);
        add(0, 2'b00, 43, 1, 0, 0); add(0, 2'b00, 43, 1, 0, 0); add(0, 2'b00, 43, 1, 0, 0);
        add(0, 2'b00, 43, 2, 1, 0);
        add(0, 2'b01, 44, 2, 1, 0); add(0, 2'b01, 45, 1, 0, 0);
        add(0, 2'b00, 45, 1, 0, 0); add(0, 2'b00, 45, 1, 0, 0); add(0, 2'b00, 45, 1, 0, 0);
        add(0, 2'b00, 45, 2, 1, 0);
        add(0, 2'b01, 46, 2, 1, 0); add(0, 2'b10, 45, 2, 1, 0); add(0, 2'b01, 46, 2, 1, 0);
        add(0, 2'b01, 47, 1, 0, 0);
        // Upper saturation in COARSE.
        add(1, 2'b01, 36, 0, 0, 0); add(0, 2'b01, 40, 0, 0, 0); add(0, 2'b01, 44, 0, 0, 0);
        add(0, 2'b01, 48, 0, 0, 0); add(0, 2'b01, 52, 0, 0, 0); add(0, 2'b01, 56, 0, 0, 0);
        add(0, 2'b01, 60, 0, 0, 0); add(0, 2'b01, 63, 0, 0, 0); add(0, 2'b01, 63, 0, 0, 1);
        add(0, 2'b00, 63, 0, 0, 0);
        // Lower saturation; INVALID in COARSE is a no-op.
        add(1, 2'b11, 32, 0, 0, 0);
        add(0, 2'b10, 28, 0, 0, 0); add(0, 2'b10, 24, 0, 0, 0); add(0, 2'b10, 20, 0, 0, 0);
        add(0, 2'b10, 16, 0, 0, 0); add(0, 2'b10, 12, 0, 0, 0); add(0, 2'b10, 8, 0, 0, 0);
        add(0, 2'b10, 4, 0, 0, 0);  add(0, 2'b10, 0, 0, 0, 0);  add(0, 2'b10, 0, 0, 0, 1);
        add(0, 2'b01, 1, 1, 0, 0);

        model_reset();
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst_first) do_reset();
            strobe(vt[i].sel, 1 + (i % 3), c, st, lk, sa);
            chk($sformatf("vec%0d_code", i), c, vt[i].code);
            chk($sformatf("vec%0d_state", i), st, vt[i].st);
            chk($sformatf("vec%0d_lock", i), lk, vt[i].lock);
            chk($sformatf("vec%0d_sat", i), sa, vt[i].sat);
        end

        // DIV_M held high through reset release must not create an update.
        @(negedge clk_ext);
        rst = 1'b1; DIV_M = 1'b1; Sel = 2'b01;
        repeat (2) @(negedge clk_ext);
        rst = 1'b0;
        repeat (3) @(negedge clk_ext);
        chk("hi_rel_code", int'(Code), INIT);
        chk("hi_rel_state", int'(State), 0);
        chk("hi_rel_lock", int'(Lock), 0);
        chk("hi_rel_sat", int'(Sat), 0);
        DIV_M = 1'b0;
        model_reset();
        strobe(2'b01, 1, c, st, lk, sa);
        chk("hi_rel_first_upd", c, 36);

        // Reset asserted in the same cycle as an update aborts it, asynchronously.
        @(negedge clk_ext);
        DIV_M = 1'b1; Sel = 2'b01;
        #2 rst = 1'b1;
        #1 chk("async_rst_code", int'(Code), INIT);
        @(negedge clk_ext);
        rst = 1'b0;
        repeat (2) @(negedge clk_ext);
        chk("abort_code", int'(Code), INIT);
        chk("abort_state", int'(State), 0);
        DIV_M = 1'b0;
        model_reset();
        strobe(2'b01, 5, c, st, lk, sa);
        chk("wide_pulse_code", c, 36);
        strobe(2'b01, 1, c, st, lk, sa);
        chk("narrow_pulse_code", c, 40);

        // Random decisions, widths and occasional resets against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            r = $urandom_range(0, 9);
            s = (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : (r < 9) ? 2'b00 : 2'b11;
            w = $urandom_range(1, 3);
            strobe(s, w, c, st, lk, sa);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk_ext);
                Sel = 2'($urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
